// File: rtl/instr_loader_if.sv
// instr_loader_if: byte stream in and instruction memory write bus out of the program loader
//   byteIn/byteValid/byteReady : valid/ready byte stream into the loader
//   memAddy/memData/memWrite   : one-cycle word write strobe into instruction memory
//   master = stream source / memory side, slave = loader side
interface instr_loader_if;
  logic [7:0] byteIn;
  logic byteValid;
  logic byteReady;
  logic [9:0] memAddy;
  logic [31:0] memData;
  logic memWrite;
  modport master (output byteIn, byteValid, input byteReady, memAddy, memData, memWrite);
  modport slave (input byteIn, byteValid, output byteReady, memAddy, memData, memWrite);
endinterface

// File: rtl/instr_loader.sv
// instr_loader: packs a byte stream MSB-first into 32-bit words and writes them to instruction memory
//   clock, reset_n (async active-low)
//   start, baseAddy, loadLength : load request, sampled only in IDLE
//   bus (slave)                  : byte stream handshake and memory write strobe
//   cpuStall, busy               : high while a load is in progress
//   done, error                  : one-cycle completion / rejection (or checksum failure) pulses
//   INSTR_LOADER_CHECKSUM_EN     : when defined, one XOR checksum byte follows the data
module instr_loader (
  input  logic clock,
  input  logic reset_n,
  input  logic start,
  input  logic [9:0] baseAddy,
  input  logic [10:0] loadLength,
  instr_loader_if.slave bus,
  output logic cpuStall,
  output logic busy,
  output logic done,
  output logic error
);
`ifdef INSTR_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, RECV, WRITE, CHECK, DONE} state_t;
  logic [7:0] csum;
`else
  typedef enum logic [2:0] {IDLE, RECV, WRITE, DONE} state_t;
`endif
  state_t state;
  logic [9:0] addr;
  logic [10:0] len, words;
  logic [1:0] bcnt;
  logic [23:0] part;
  assign cpuStall = busy;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      addr <= '0;
      len <= '0;
      words <= '0;
      bcnt <= '0;
      part <= '0;
      bus.byteReady <= 1'b0;
      bus.memAddy <= '0;
      bus.memData <= '0;
      bus.memWrite <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
      csum <= '0;
`endif
    end else begin
      done <= 1'b0;
      error <= 1'b0;
      bus.memWrite <= 1'b0;
      case (state)
        IDLE: if (start) begin
          if (loadLength == 11'd0 || loadLength > 11'd1024) error <= 1'b1;
          else begin
            addr <= baseAddy;
            len <= loadLength;
            words <= '0;
            bcnt <= '0;
            bus.byteReady <= 1'b1;
            busy <= 1'b1;
            state <= RECV;
`ifdef INSTR_LOADER_CHECKSUM_EN
            csum <= '0;
`endif
          end
        end
        RECV: if (bus.byteValid) begin
          bcnt <= bcnt + 2'd1;
          part <= {part[15:0], bus.byteIn};
`ifdef INSTR_LOADER_CHECKSUM_EN
          csum <= csum ^ bus.byteIn;
`endif
          // the 4th byte completes the word; address and data are latched together so they stay put
          if (bcnt == 2'd3) begin
            bus.memData <= {part, bus.byteIn};
            bus.memAddy <= addr;
            bus.memWrite <= 1'b1;
            bus.byteReady <= 1'b0;
            words <= words + 11'd1;
            state <= WRITE;
          end
        end
        WRITE: if (words == len) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
          bus.byteReady <= 1'b1;
          state <= CHECK;
`else
          done <= 1'b1;
          state <= DONE;
`endif
        end else begin
          addr <= addr + 10'd1;
          bus.byteReady <= 1'b1;
          state <= RECV;
        end
`ifdef INSTR_LOADER_CHECKSUM_EN
        CHECK: if (bus.byteValid) begin
          bus.byteReady <= 1'b0;
          if (bus.byteIn == csum) begin
            done <= 1'b1;
            state <= DONE;
          end else begin
            error <= 1'b1;
            busy <= 1'b0;
            state <= IDLE;
          end
        end
`endif
        DONE: begin
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: directed loads checked against a word-level model of the expected memory writes
module tb_instr_loader;
  typedef logic [7:0] bq_t[$];
`ifdef INSTR_LOADER_CHECKSUM_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  logic clock = 0, reset_n = 0, start = 0;
  logic [9:0] baseAddy = 0;
  logic [10:0] loadLength = 0;
  logic cpuStall, busy, done, error;
  instr_loader_if bus();
  instr_loader dut (
    .clock(clock), .reset_n(reset_n), .start(start), .baseAddy(baseAddy), .loadLength(loadLength),
    .bus(bus.slave), .cpuStall(cpuStall), .busy(busy), .done(done), .error(error)
  );
  always #5 clock = ~clock;
  int passed = 0, total = 0, cyc = 0, last_wr = -100, writes = 0;
  logic [9:0] exp_addr[$];
  logic [31:0] exp_data[$];
  always @(posedge clock) cyc <= cyc + 1;
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  always @(negedge clock) if (reset_n) begin
    check("stall_eq_busy", {31'd0, cpuStall}, {31'd0, busy});
    if (bus.memWrite) begin
      writes++;
      last_wr = cyc;
      if (exp_addr.size() == 0) begin
        total++;
        $display("FAIL unexpected_write: got write %h@%h expected none", bus.memData, bus.memAddy);
      end else begin
        check("wr_addr", {22'd0, bus.memAddy}, {22'd0, exp_addr.pop_front()});
        check("wr_data", bus.memData, exp_data.pop_front());
      end
    end
  end
  function automatic logic [7:0] xor_all(bq_t b);
    logic [7:0] x = 0;
    foreach (b[i]) x ^= b[i];
    return x;
  endfunction
  task automatic expect_load(logic [9:0] base, bq_t b);
    for (int i = 0; i < b.size() / 4; i++) begin
      exp_addr.push_back(base + 10'(i));
      exp_data.push_back({b[4*i], b[4*i+1], b[4*i+2], b[4*i+3]});
    end
  endtask
  task automatic do_start(logic [9:0] base, logic [10:0] len);
    baseAddy = base;
    loadLength = len;
    start = 1;
    @(negedge clock);
    start = 0;
  endtask
  task automatic send(logic [7:0] b, int gap);
    int n = 0;
    bus.byteIn = b;
    bus.byteValid = 1;
    while (!bus.byteReady && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (n == 50) begin
      total++;
      $display("FAIL send_timeout: got byteReady low for %0d cycles expected high", n);
    end
    @(negedge clock);
    bus.byteValid = 0;
    repeat (gap) @(negedge clock);
  endtask
  task automatic wait_done();
    int n = 0;
    while (!done && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("done_seen", {31'd0, done}, 32'd1);
    check("done_latency", cyc - last_wr, LAT);
    check("queue_drained", exp_addr.size(), 0);
    @(negedge clock);
    check("done_one_cycle", {31'd0, done}, 32'd0);
    check("idle_not_busy", {31'd0, busy}, 32'd0);
  endtask
  task automatic load(logic [9:0] base, logic [10:0] len, bq_t b, int gap);
    expect_load(base, b);
    do_start(base, len);
    check("busy_after_start", {31'd0, busy}, 32'd1);
    check("ready_after_start", {31'd0, bus.byteReady}, 32'd1);
    foreach (b[i]) send(b[i], gap);
`ifdef INSTR_LOADER_CHECKSUM_EN
    send(xor_all(b), 0);
`endif
    wait_done();
  endtask
  bq_t q;
  initial begin
    bus.byteIn = 0;
    bus.byteValid = 0;
    repeat (2) @(negedge clock);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_stall", {31'd0, cpuStall}, 0);
    check("rst_ready", {31'd0, bus.byteReady}, 0);
    check("rst_write", {31'd0, bus.memWrite}, 0);
    check("rst_addr", {22'd0, bus.memAddy}, 0);
    check("rst_data", bus.memData, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_error", {31'd0, error}, 0);
    reset_n = 1;
    @(negedge clock);
    q = '{8'h3C, 8'h02, 8'h00, 8'h02, 8'h58, 8'h40, 8'h00, 8'h00};
    check("model_word0", {q[0], q[1], q[2], q[3]}, 32'h3C020002);
    check("model_xor", {24'd0, xor_all('{8'h11, 8'h22, 8'h33, 8'h44})}, 32'h44);
    load(10'd0, 11'd2, q, 0);
    check("basic_writes", writes, 2);
    check("basic_addr_hold", {22'd0, bus.memAddy}, 32'd1);
    check("basic_data_hold", bus.memData, 32'h58400000);
    q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67};
    load(10'd1023, 11'd2, q, 1);
    check("wrap_writes", writes, 4);
    check("wrap_addr_hold", {22'd0, bus.memAddy}, 32'd0);
    check("wrap_data_hold", bus.memData, 32'h01234567);
    do_start(10'd7, 11'd0);
    check("rej0_error", {31'd0, error}, 1);
    check("rej0_busy", {31'd0, busy}, 0);
    @(negedge clock);
    check("rej0_error_clear", {31'd0, error}, 0);
    do_start(10'd7, 11'd1025);
    check("rej1025_error", {31'd0, error}, 1);
    check("rej1025_busy", {31'd0, busy}, 0);
    @(negedge clock);
    check("rej1025_error_clear", {31'd0, error}, 0);
    q = '{8'hCA, 8'hFE, 8'hF0, 8'h0D};
    expect_load(10'd5, q);
    do_start(10'd5, 11'd1);
    send(q[0], 0);
    send(q[1], 0);
    do_start(10'd100, 11'd3);
    check("ignored_start_busy", {31'd0, busy}, 1);
    check("ignored_start_ready", {31'd0, bus.byteReady}, 1);
    check("ignored_start_error", {31'd0, error}, 0);
    send(q[2], 0);
    send(q[3], 0);
`ifdef INSTR_LOADER_CHECKSUM_EN
    send(xor_all(q), 0);
`endif
    wait_done();
    check("ignored_start_writes", writes, 5);
    do_start(10'd10, 11'd1);
    send(8'hAA, 0);
    send(8'hBB, 0);
    reset_n = 0;
    #1;
    check("midrst_busy", {31'd0, busy}, 0);
    check("midrst_stall", {31'd0, cpuStall}, 0);
    check("midrst_ready", {31'd0, bus.byteReady}, 0);
    check("midrst_addr", {22'd0, bus.memAddy}, 0);
    check("midrst_data", bus.memData, 0);
    check("midrst_write", {31'd0, bus.memWrite}, 0);
    @(negedge clock);
    reset_n = 1;
    @(negedge clock);
    q = '{8'h12, 8'h34, 8'h56, 8'h78};
    load(10'd20, 11'd1, q, 0);
    check("post_rst_writes", writes, 6);
`ifdef INSTR_LOADER_CHECKSUM_EN
    q = '{8'h11, 8'h22, 8'h33, 8'h44};
    load(10'd30, 11'd1, q, 0);
    expect_load(10'd31, q);
    do_start(10'd31, 11'd1);
    foreach (q[i]) send(q[i], 0);
    send(8'h00, 0);
    check("bad_csum_error", {31'd0, error}, 1);
    check("bad_csum_no_done", {31'd0, done}, 0);
    @(negedge clock);
    check("bad_csum_idle", {31'd0, busy}, 0);
    check("bad_csum_no_done_late", {31'd0, done}, 0);
    check("bad_csum_word_written", writes, 8);
`endif
    repeat (2) @(negedge clock);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
